// File: rtl/reg_file_pkg.sv
// Shared register-file definitions used by the writeback queue and the
// register file itself.
//   RF_DATA_WIDTH : default register data width
//   RF_ADDR_WIDTH : default register address width (32 registers)
//   REG_ZERO      : hard-wired zero register; writes to it are dropped
package reg_file_pkg;
  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int REG_ZERO      = 0;
endpackage

// File: rtl/fwd_lookup.sv
// Forwarding lookup over the pending-write FIFO.
// Entries are scanned in age order starting at the head, so the last match
// found is the youngest pending write to that register.
//   i_la    : lookup address
//   i_addr  : entry address storage (indexed by FIFO slot)
//   i_data  : entry data storage
//   i_head  : slot of the oldest pending entry
//   i_count : number of pending entries
//   o_hit   : a pending write to i_la exists (never for the zero register)
//   o_data  : youngest matching data, 0 on miss
module fwd_lookup
  import reg_file_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]            i_la,
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] i_addr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] i_data,
  input  logic [$clog2(DEPTH)-1:0]         i_head,
  input  logic [$clog2(DEPTH):0]           i_count,
  output logic                             o_hit,
  output logic [DATA_WIDTH-1:0]            o_data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if ((k < int'(i_count)) && (i_la != ADDR_WIDTH'(REG_ZERO)) &&
          (i_addr[w_idx] == i_la)) begin
        o_hit  = 1'b1;
        o_data = i_data[w_idx];
      end
    end
  end
endmodule

// File: rtl/reg_write_queue.sv
// Register writeback queue: in-order FIFO of {addr, data} writes that drains
// into the register file write port one entry per cycle unless HOLD is set,
// with two combinational forwarding lookups for operand reads.
//   CLOCK, RESET          : clock, synchronous active-high reset
//   IN_VALID/IN_READY     : request handshake, IN_ADDR/IN_DATA payload
//   HOLD                  : register file write port busy, stalls draining
//   WE/A3/WD              : register file write port (head entry)
//   LA1/LA2               : forwarding lookup addresses
//   FWDn_HIT/FWDn_DATA    : youngest pending write for LAn
//   COUNT                 : number of pending entries
module reg_write_queue
  import reg_file_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [ADDR_WIDTH-1:0]   IN_ADDR,
  input  logic [DATA_WIDTH-1:0]   IN_DATA,
  input  logic                    HOLD,
  output logic [ADDR_WIDTH-1:0]   A3,
  output logic                    WE,
  output logic [DATA_WIDTH-1:0]   WD,
  input  logic [ADDR_WIDTH-1:0]   LA1,
  input  logic [ADDR_WIDTH-1:0]   LA2,
  output logic                    FWD1_HIT,
  output logic                    FWD2_HIT,
  output logic [DATA_WIDTH-1:0]   FWD1_DATA,
  output logic [DATA_WIDTH-1:0]   FWD2_DATA,
  output logic [$clog2(DEPTH):0]  COUNT
);
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   C_DEPTH = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] r_addr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
  logic [PW-1:0]                    r_wr_ptr;
  logic [PW-1:0]                    r_rd_ptr;
  logic [PW:0]                      r_count;

  logic w_accept;
  logic w_push;
  logic w_pop;

  assign IN_READY = (r_count < C_DEPTH);
  assign w_accept = IN_VALID && IN_READY;
  // Writes to the zero register complete the handshake but are not stored.
  assign w_push   = w_accept && !RESET && (IN_ADDR != ADDR_WIDTH'(REG_ZERO));
  assign w_pop    = (r_count != '0) && !HOLD;

  assign WE    = w_pop;
  assign A3    = w_pop ? r_addr[r_rd_ptr] : '0;
  assign WD    = w_pop ? r_data[r_rd_ptr] : '0;
  assign COUNT = r_count;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

  // Slot storage needs no reset: occupancy is defined by pointers and count.
  always_ff @(posedge CLOCK) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= IN_ADDR;
      r_data[r_wr_ptr] <= IN_DATA;
    end
  end

  fwd_lookup #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd1 (
    .i_la(LA1), .i_addr(r_addr), .i_data(r_data), .i_head(r_rd_ptr),
    .i_count(r_count), .o_hit(FWD1_HIT), .o_data(FWD1_DATA)
  );

  fwd_lookup #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd2 (
    .i_la(LA2), .i_addr(r_addr), .i_data(r_data), .i_head(r_rd_ptr),
    .i_count(r_count), .o_hit(FWD2_HIT), .o_data(FWD2_DATA)
  );
endmodule

// File: tb/tb_reg_write_queue.sv
module tb_reg_write_queue;
  localparam int DEPTH = 4;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [4:0] IN_ADDR = '0;
  logic [7:0] IN_DATA = '0;
  logic       HOLD = 1'b0;
  logic [4:0] A3;
  logic       WE;
  logic [7:0] WD;
  logic [4:0] LA1 = '0;
  logic [4:0] LA2 = '0;
  logic       FWD1_HIT, FWD2_HIT;
  logic [7:0] FWD1_DATA, FWD2_DATA;
  logic [2:0] COUNT;

  int vecs = 0;
  int errs = 0;

  reg_write_queue #(.DEPTH(DEPTH), .DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .HOLD(HOLD), .A3(A3), .WE(WE), .WD(WD),
    .LA1(LA1), .LA2(LA2), .FWD1_HIT(FWD1_HIT), .FWD2_HIT(FWD2_HIT),
    .FWD1_DATA(FWD1_DATA), .FWD2_DATA(FWD2_DATA), .COUNT(COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  // Reference model: a queue of pending writes, oldest at the front.
  typedef struct packed { logic [4:0] a; logic [7:0] d; } ent_t;
  ent_t mq[$];

  // Full observable output vector: COUNT,IN_READY,WE,A3,WD,H1,D1,H2,D2
  logic [35:0] act_vec;
  assign act_vec = {COUNT, IN_READY, WE, A3, WD, FWD1_HIT, FWD1_DATA, FWD2_HIT, FWD2_DATA};

  function automatic logic [8:0] model_fwd(input logic [4:0] la);
    logic [8:0] r = '0;
    if (la != 0)
      foreach (mq[i]) if (mq[i].a == la) r = {1'b1, mq[i].d};
    return r;
  endfunction

  function automatic logic [35:0] model_vec();
    logic       we = (mq.size() != 0) && !HOLD;
    logic [4:0] a3 = we ? mq[0].a : 5'd0;
    logic [7:0] wd = we ? mq[0].d : 8'd0;
    return {3'(mq.size()), 1'(mq.size() < DEPTH), we, a3, wd, model_fwd(LA1), model_fwd(LA2)};
  endfunction

  // Advance one clock and apply the spec rules to the model.
  task automatic tick();
    bit acc = IN_VALID && (mq.size() < DEPTH);
    bit pop = (mq.size() != 0) && !HOLD;
    @(posedge CLOCK);
    if (RESET) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc && IN_ADDR != 0) mq.push_back({IN_ADDR, IN_DATA});
    end
    #1;
  endtask

  task automatic test_reset();
    RESET = 1; IN_VALID = 1; IN_ADDR = 5'd3; IN_DATA = 8'h99; HOLD = 0;
    tick(); tick();
    RESET = 0; IN_VALID = 0; LA1 = 5'd3; LA2 = 5'd3; #1;
    vecs++;
    if (act_vec !== {3'd0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0}) begin
      errs++; $display("FAIL reset_state got=%h want=%h", act_vec, {3'd0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 8'd0, 1'b0, 8'd0});
    end
  endtask

  task automatic test_single();
    HOLD = 0; IN_VALID = 1; IN_ADDR = 5'd5; IN_DATA = 8'h3C; #1;
    vecs++;
    if (WE !== 1'b0) begin errs++; $display("FAIL single_no_bypass WE got=%b want=0", WE); end
    tick(); IN_VALID = 0; #1;
    vecs++;
    if ({WE, A3, WD, COUNT} !== {1'b1, 5'd5, 8'h3C, 3'd1}) begin
      errs++; $display("FAIL single_write got we=%b a3=%0d wd=%h cnt=%0d want 1/5/3c/1", WE, A3, WD, COUNT);
    end
    tick();
    vecs++;
    if ({WE, COUNT} !== {1'b0, 3'd0}) begin
      errs++; $display("FAIL single_drained got we=%b cnt=%0d want 0/0", WE, COUNT);
    end
  endtask

  task automatic test_hold_full();
    HOLD = 1;
    for (int i = 1; i <= 4; i++) begin
      IN_VALID = 1; IN_ADDR = 5'(i); IN_DATA = 8'(8'h11 * i); tick();
    end
    IN_ADDR = 5'd9; IN_DATA = 8'h99; #1;
    vecs++;
    if ({COUNT, IN_READY, WE} !== {3'd4, 1'b0, 1'b0}) begin
      errs++; $display("FAIL full_state got cnt=%0d rdy=%b we=%b want 4/0/0", COUNT, IN_READY, WE);
    end
    tick();
    vecs++;
    if (COUNT !== 3'd4) begin errs++; $display("FAIL full_reject got cnt=%0d want 4", COUNT); end
    IN_VALID = 0; HOLD = 0; #1;
    for (int i = 1; i <= 4; i++) begin
      vecs++;
      if ({WE, A3, WD} !== {1'b1, 5'(i), 8'(8'h11 * i)}) begin
        errs++; $display("FAIL drain_%0d got we=%b a3=%0d wd=%h want 1/%0d/%h", i, WE, A3, WD, i, 8'(8'h11 * i));
      end
      tick();
    end
    vecs++;
    if ({WE, COUNT} !== {1'b0, 3'd0}) begin errs++; $display("FAIL drain_end got we=%b cnt=%0d", WE, COUNT); end
  endtask

  task automatic test_fwd_youngest();
    HOLD = 1; IN_VALID = 1;
    IN_ADDR = 5'd7; IN_DATA = 8'hAA; tick();
    IN_ADDR = 5'd7; IN_DATA = 8'hBB; tick();
    IN_VALID = 0; LA1 = 5'd7; LA2 = 5'd8; #1;
    vecs++;
    if ({FWD1_HIT, FWD1_DATA, FWD2_HIT, FWD2_DATA} !== {1'b1, 8'hBB, 1'b0, 8'h00}) begin
      errs++; $display("FAIL fwd_youngest got %b/%h %b/%h want 1/bb 0/00", FWD1_HIT, FWD1_DATA, FWD2_HIT, FWD2_DATA);
    end
    LA2 = 5'd7; #1;
    vecs++;
    if ({FWD2_HIT, FWD2_DATA} !== {1'b1, 8'hBB}) begin
      errs++; $display("FAIL fwd_same_la got %b/%h want 1/bb", FWD2_HIT, FWD2_DATA);
    end
    // Request on the input but not yet accepted must not forward.
    IN_VALID = 1; IN_ADDR = 5'd8; IN_DATA = 8'h55; LA2 = 5'd8; #1;
    vecs++;
    if (FWD2_HIT !== 1'b0) begin errs++; $display("FAIL fwd_unaccepted got hit=%b want 0", FWD2_HIT); end
    IN_VALID = 0; HOLD = 0; tick(); tick();
    vecs++;
    if (act_vec !== model_vec()) begin errs++; $display("FAIL fwd_drain got=%h want=%h", act_vec, model_vec()); end
  endtask

  task automatic test_zero_reg();
    HOLD = 0; IN_VALID = 1; IN_ADDR = 5'd0; IN_DATA = 8'hFF; LA1 = 5'd0; #1;
    vecs++;
    if (IN_READY !== 1'b1) begin errs++; $display("FAIL zero_ready got=%b want 1", IN_READY); end
    tick(); IN_VALID = 0;
    for (int c = 0; c < 2; c++) begin
      #1; vecs++;
      if ({COUNT, WE, FWD1_HIT} !== {3'd0, 1'b0, 1'b0}) begin
        errs++; $display("FAIL zero_drop got cnt=%0d we=%b hit=%b want 0/0/0", COUNT, WE, FWD1_HIT);
      end
      tick();
    end
  endtask

  task automatic test_reset_pending();
    HOLD = 1; IN_VALID = 1;
    for (int i = 0; i < 3; i++) begin IN_ADDR = 5'(10 + i); IN_DATA = 8'(i); tick(); end
    IN_VALID = 0; #1;
    vecs++;
    if (COUNT !== 3'd3) begin errs++; $display("FAIL rstp_fill got cnt=%0d want 3", COUNT); end
    RESET = 1; tick(); RESET = 0; #1;
    vecs++;
    if ({COUNT, WE} !== {3'd0, 1'b0}) begin errs++; $display("FAIL rstp_clear got cnt=%0d we=%b", COUNT, WE); end
    HOLD = 0;
    for (int c = 0; c < 3; c++) begin
      #1; vecs++;
      if (WE !== 1'b0) begin errs++; $display("FAIL rstp_nowrite cyc%0d got we=%b want 0", c, WE); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[1:10];
    HOLD = 0;
    for (int i = 1; i <= 10; i++) d[i] = 8'($urandom);
    for (int i = 1; i <= 10; i++) begin
      IN_VALID = 1; IN_ADDR = 5'(i); IN_DATA = d[i]; tick();
      #1; vecs++;
      if ({COUNT, WE, A3, WD} !== {3'd1, 1'b1, 5'(i), d[i]}) begin
        errs++; $display("FAIL stream_%0d got cnt=%0d we=%b a3=%0d wd=%h want 1/1/%0d/%h", i, COUNT, WE, A3, WD, i, d[i]);
      end
    end
    IN_VALID = 0; tick();
    vecs++;
    if ({COUNT, WE} !== {3'd0, 1'b0}) begin errs++; $display("FAIL stream_end got cnt=%0d we=%b", COUNT, WE); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      RESET    = ($urandom_range(0, 59) == 0);
      HOLD     = ($urandom_range(0, 2) == 0);
      IN_VALID = ($urandom_range(0, 3) != 0);
      IN_ADDR  = 5'($urandom_range(0, 7));
      IN_DATA  = 8'($urandom);
      LA1      = 5'($urandom_range(0, 7));
      LA2      = 5'($urandom_range(0, 7));
      #1; vecs++;
      if (act_vec !== model_vec()) begin
        errs++; $display("FAIL random cyc%0d got=%h want=%h", c, act_vec, model_vec());
      end
      tick();
    end
    RESET = 0; IN_VALID = 0; HOLD = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_full();
    test_fwd_youngest();
    test_zero_reg();
    test_reset_pending();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
